// File: rtl/fu_arb_pkg.sv
// ----------------------------------------------------------------------------
// fu_arb_pkg
// Shared types and helpers for the six-way functional-unit arbiter (fu_arb_6)
// and its priority encoder (enc_6).
//   N_REQ           number of requesters
//   IDX_W           width of a requester index
//   fu_arb_state_t  sequencer states IDLE / ISSUE / BUSY
//   therm_mask()    thermometer mask with every bit at or above ptr set
//   onehot()        index -> one-hot requester vector
//   next_idx()      index + 1, wrapping from N_REQ-1 back to 0
// ----------------------------------------------------------------------------
package fu_arb_pkg;

    localparam int N_REQ = 6;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } fu_arb_state_t;

    function automatic logic [N_REQ-1:0] therm_mask(input logic [IDX_W-1:0] ptr);
        logic [N_REQ-1:0] m;
        for (int i = 0; i < N_REQ; i++) begin
            m[i] = (i >= int'(ptr));
        end
        return m;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ-1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/enc_6.sv
// ----------------------------------------------------------------------------
// enc_6
// Six-input lowest-index priority encoder.
//   req  in   6  request vector
//   idx  out  3  index of the lowest set bit (0 when none set)
//   vld  out  1  at least one request bit set
// ----------------------------------------------------------------------------
module enc_6
    import fu_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        vld = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fu_arb_6.sv
// ----------------------------------------------------------------------------
// fu_arb_6
// Round-robin arbiter/sequencer sharing one multi-cycle functional unit among
// six requesters. Owns the unit's start/ready/done handshake and advances a
// fairness pointer after every completed (or aborted) operation.
//
// Optional feature: define FU_ARB_6_TIMEOUT_EN to enable a BUSY watchdog that
// aborts the unit after TIMEOUT_CYCLES cycles and sets the sticky err_o.
// Without it, BUSY waits indefinitely and fu_abort_o / err_o are tied low.
//
// Parameters
//   TIMEOUT_CYCLES  BUSY cycle limit before abort (2..255), watchdog only
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   req_i       in   6  per-requester request
//   gnt_o       out  6  one-hot pulse when the unit accepts the owner's op
//   done_o      out  6  one-hot pulse when the owner's op completes
//   fu_start_o  out  1  start request to the unit
//   fu_sel_o    out  3  current owner index (operand mux select)
//   fu_ready_i  in   1  unit accepts start this cycle
//   fu_done_i   in   1  unit result valid (single-cycle pulse)
//   fu_abort_o  out  1  pulse that kills the unit's operation
//   busy_o      out  1  high in ISSUE or BUSY
//   err_o       out  1  sticky timeout flag
// ----------------------------------------------------------------------------
module fu_arb_6
    import fu_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] done_o,
    output logic             fu_start_o,
    output logic [IDX_W-1:0] fu_sel_o,
    input  logic             fu_ready_i,
    input  logic             fu_done_i,
    output logic             fu_abort_o,
    output logic             busy_o,
    output logic             err_o
);

    fu_arb_state_t    state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] ptr_adv;
    logic [IDX_W-1:0] ptr_arb;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] cand_m;
    logic [IDX_W-1:0] idx_m, idx_r;
    logic             vld_m, vld_r;
    logic [IDX_W-1:0] win;
    logic             any;
    logic             owner_req;
    logic             expire;

    assign owner_oh  = onehot(owner);
    assign owner_req = |(req_i & owner_oh);
    assign ptr_adv   = next_idx(owner);

    // In BUSY the arbitration runs on the done cycle for the zero-bubble
    // hand-off: the owner is excluded and the pointer it is about to leave
    // behind is used, so the result matches a fresh IDLE arbitration.
    assign cand    = (state == BUSY) ? (req_i & ~owner_oh) : req_i;
    assign ptr_arb = (state == BUSY) ? ptr_adv : ptr;
    assign cand_m  = cand & therm_mask(ptr_arb);

    enc_6 u_enc_masked (
        .req (cand_m),
        .idx (idx_m),
        .vld (vld_m)
    );

    enc_6 u_enc_raw (
        .req (cand),
        .idx (idx_r),
        .vld (vld_r)
    );

    // Nothing at or above the pointer means the search wraps to index 0.
    assign win = vld_m ? idx_m : idx_r;
    assign any = vld_r;

`ifdef FU_ARB_6_TIMEOUT_EN
    logic [7:0] cnt;
    logic       err;

    // A done in the expiry cycle takes priority, so expiry requires !fu_done_i.
    assign expire = (state == BUSY) && !fu_done_i &&
                    (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                cnt <= '0;
            end else if ((state == BUSY) && !fu_done_i && !expire) begin
                cnt <= cnt + 8'd1;
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

    assign fu_abort_o = expire;
    assign err_o      = err;
`else
    logic [7:0] unused_tmo;

    assign unused_tmo = 8'(TIMEOUT_CYCLES);
    assign expire     = 1'b0;
    assign fu_abort_o = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (any) begin
                    owner_nxt = win;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A withdrawn request abandons the slot even if the unit is ready.
                if (!owner_req) begin
                    state_nxt = IDLE;
                end else if (fu_ready_i) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (fu_done_i) begin
                    ptr_nxt = ptr_adv;
                    if (any) begin
                        owner_nxt = win;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (expire) begin
                    ptr_nxt   = ptr_adv;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fu_start_o = (state == ISSUE);
    assign fu_sel_o   = owner;
    assign busy_o     = (state != IDLE);
    assign gnt_o      = ((state == ISSUE) && owner_req && fu_ready_i) ? owner_oh : '0;
    assign done_o     = ((state == BUSY) && fu_done_i) ? owner_oh : '0;

endmodule

// File: tb/tb_fu_arb_6.sv
// ----------------------------------------------------------------------------
// tb_fu_arb_6
// Directed scenarios with literal expectations followed by randomized traffic,
// all cross-checked every cycle against a behavioural round-robin model.
// Define FU_ARB_6_TIMEOUT_EN to exercise the watchdog build.
// ----------------------------------------------------------------------------
module tb_fu_arb_6;

    localparam int TMO = 8;
`ifdef FU_ARB_6_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] req_i;
    logic [5:0] gnt_o;
    logic [5:0] done_o;
    logic       fu_start_o;
    logic [2:0] fu_sel_o;
    logic       fu_ready_i;
    logic       fu_done_i;
    logic       fu_abort_o;
    logic       busy_o;
    logic       err_o;

    int n_vec = 0;
    int n_err = 0;

    fu_arb_6 #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .fu_start_o (fu_start_o),
        .fu_sel_o   (fu_sel_o),
        .fu_ready_i (fu_ready_i),
        .fu_done_i  (fu_done_i),
        .fu_abort_o (fu_abort_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Round-robin search starting at p: first requester at or after p, wrapping.
    function automatic int pick(logic [5:0] c, int p);
        for (int k = 0; k < 6; k++) begin
            int i;
            i = (p + k) % 6;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural model: phase 0 = idle, 1 = issuing, 2 = unit running.
    int m_st  = 0;
    int m_own = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;

    always @(negedge clk) begin
        logic [18:0] act_v;
        logic [18:0] exp_v;
        logic [5:0]  eg;
        logic [5:0]  ed;
        logic        ea;
        int          w;
        act_v = {gnt_o, done_o, fu_start_o, fu_sel_o, fu_abort_o, busy_o, err_o};
        if (!rst_n) begin
            chk("reset_outputs", 32'(act_v), 32'd0);
            m_st  = 0;
            m_own = 0;
            m_ptr = 0;
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            eg = (m_st == 1 && req_i[m_own] && fu_ready_i) ? 6'(1 << m_own) : 6'd0;
            ed = (m_st == 2 && fu_done_i) ? 6'(1 << m_own) : 6'd0;
            ea = TMO_EN && (m_st == 2) && !fu_done_i && (m_cnt == TMO - 1);
            exp_v = {eg, ed, (m_st == 1), 3'(m_own), ea, (m_st != 0), m_err};
            chk("cycle_outputs", 32'(act_v), 32'(exp_v));
            case (m_st)
                0: begin
                    w = pick(req_i, m_ptr);
                    if (w >= 0) begin
                        m_own = w;
                        m_st  = 1;
                    end
                end
                1: begin
                    if (!req_i[m_own]) begin
                        m_st = 0;
                    end else if (fu_ready_i) begin
                        m_st  = 2;
                        m_cnt = 0;
                    end
                end
                2: begin
                    if (fu_done_i) begin
                        m_ptr = (m_own + 1) % 6;
                        w = pick(req_i & ~6'(1 << m_own), m_ptr);
                        if (w >= 0) begin
                            m_own = w;
                            m_st  = 1;
                        end else begin
                            m_st = 0;
                        end
                    end else if (ea) begin
                        m_ptr = (m_own + 1) % 6;
                        m_err = 1'b1;
                        m_st  = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                default: m_st = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    initial begin
        logic [5:0] g;
        logic       inb;
        rst_n      = 1'b0;
        req_i      = 6'd0;
        fu_ready_i = 1'b0;
        fu_done_i  = 1'b0;

        // Reset, then a quiet idle period.
        #12;
        chk("rst_all_zero", 32'({gnt_o, done_o, fu_start_o, fu_sel_o, fu_abort_o, busy_o, err_o}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            look();
            chk("idle_no_start", 32'(fu_start_o), 32'd0);
        end

        // ptr=0, requests 2 and 5: 2 first, then 5.
        req_i      = 6'b100100;
        fu_ready_i = 1'b1;
        look();
        chk("t2_idle_cycle", 32'(fu_start_o), 32'd0);
        tick(); look();
        chk("t2_start", 32'(fu_start_o), 32'd1);
        chk("t2_sel", 32'(fu_sel_o), 32'd2);
        chk("t2_gnt", 32'(gnt_o), 32'b000100);
        tick(); req_i = 6'b100000; look();
        chk("t2_busy", 32'({busy_o, fu_start_o}), 32'b10);
        tick(); fu_done_i = 1'b1; look();
        chk("t2_done", 32'(done_o), 32'b000100);
        tick(); fu_done_i = 1'b0; look();
        chk("t2_next_start", 32'(fu_start_o), 32'd1);
        chk("t2_next_sel", 32'(fu_sel_o), 32'd5);
        chk("t2_next_gnt", 32'(gnt_o), 32'b100000);
        tick(); req_i = 6'd0;
        tick(); fu_done_i = 1'b1; look();
        chk("t2_done5", 32'(done_o), 32'b100000);
        tick(); fu_done_i = 1'b0; look();
        chk("t2_idle", 32'(busy_o), 32'd0);

        // All six requesting, done 3 cycles after each grant: 0..5,0 back-to-back.
        req_i = 6'h3F;
        tick();
        for (int k = 0; k < 7; k++) begin
            look();
            chk("rr_start", 32'(fu_start_o), 32'd1);
            chk("rr_sel", 32'(fu_sel_o), 32'(k % 6));
            chk("rr_gnt", 32'(gnt_o), 32'(1 << (k % 6)));
            tick(); req_i[k % 6] = 1'b0;
            tick();
            tick(); fu_done_i = 1'b1; look();
            chk("rr_done", 32'(done_o), 32'(1 << (k % 6)));
            tick(); fu_done_i = 1'b0; req_i[k % 6] = 1'b1;
        end
        // Now issuing for requester 1; withdrawing everything abandons it.
        req_i = 6'd0;
        tick(); look();
        chk("rr_withdraw_idle", 32'(busy_o), 32'd0);

        // Withdrawal while the unit stalls; pointer (1) must not move.
        req_i      = 6'b001000;
        fu_ready_i = 1'b0;
        tick(); look();
        chk("wd_sel", 32'(fu_sel_o), 32'd3);
        chk("wd_gnt0", 32'(gnt_o), 32'd0);
        tick(); look();
        chk("wd_gnt1", 32'(gnt_o), 32'd0);
        tick(); req_i = 6'd0; fu_ready_i = 1'b1; look();
        chk("wd_beats_ready", 32'(gnt_o), 32'd0);
        tick(); look();
        chk("wd_idle", 32'(busy_o), 32'd0);
        req_i = 6'b000011;
        tick(); look();
        chk("wd_ptr_kept", 32'(fu_sel_o), 32'd1);
        chk("wd_ptr_gnt", 32'(gnt_o), 32'b000010);
        tick(); req_i = 6'b000001;
        tick(); fu_done_i = 1'b1; look();
        chk("wd_done1", 32'(done_o), 32'b000010);
        tick(); fu_done_i = 1'b0; look();
        chk("wd_wrap_sel", 32'(fu_sel_o), 32'd0);
        chk("wd_wrap_gnt", 32'(gnt_o), 32'b000001);
        tick(); req_i = 6'd0;
        tick(); fu_done_i = 1'b1;
        tick(); fu_done_i = 1'b0;

        // Reset in the middle of an operation owned by requester 4.
        req_i = 6'b010000;
        tick(); look();
        chk("rst_owner4", 32'(fu_sel_o), 32'd4);
        tick(); req_i = 6'd0; look();
        chk("rst_in_busy", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        look();
        chk("rst_mid_busy", 32'({gnt_o, done_o, fu_start_o, fu_sel_o, fu_abort_o, busy_o, err_o}), 32'd0);
        tick(); rst_n = 1'b1; req_i = 6'b010001;
        tick(); look();
        chk("rst_ptr0_sel", 32'(fu_sel_o), 32'd0);
        chk("rst_ptr0_gnt", 32'(gnt_o), 32'b000001);
        tick(); req_i = 6'b010000;
        tick(); fu_done_i = 1'b1;
        tick(); fu_done_i = 1'b0;
        tick(); req_i = 6'd0;
        tick(); fu_done_i = 1'b1;
        tick(); fu_done_i = 1'b0;

        // Unit never answers.
        req_i = 6'b000100;
        tick();
        tick(); req_i = 6'd0;
`ifdef FU_ARB_6_TIMEOUT_EN
        for (int b = 1; b <= TMO; b++) begin
            look();
            chk("tmo_abort", 32'(fu_abort_o), 32'(b == TMO));
            chk("tmo_no_done", 32'(done_o), 32'd0);
            if (b < TMO) tick();
        end
        tick(); look();
        chk("tmo_idle", 32'(busy_o), 32'd0);
        chk("tmo_err", 32'(err_o), 32'd1);
        repeat (5) tick();
        look();
        chk("tmo_err_sticky", 32'(err_o), 32'd1);
`else
        for (int b = 0; b < 20; b++) begin
            look();
            chk("wait_no_abort", 32'({fu_abort_o, err_o, busy_o}), 32'b001);
            tick();
        end
        fu_done_i = 1'b1; look();
        chk("wait_done", 32'(done_o), 32'b000100);
        tick(); fu_done_i = 1'b0; look();
        chk("wait_idle", 32'(busy_o), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            g = gnt_o;
            @(posedge clk);
            #1;
            inb = busy_o && !fu_start_o;
            for (int i = 0; i < 6; i++) begin
                if (g[i]) begin
                    req_i[i] = 1'b0;
                end else if (req_i[i]) begin
                    if ($urandom % 16 == 0) req_i[i] = 1'b0;
                end else if ($urandom % 5 == 0) begin
                    req_i[i] = 1'b1;
                end
            end
            fu_ready_i = ($urandom % 3 != 0);
            fu_done_i  = inb ? ($urandom % 4 == 0) : ($urandom % 20 == 0);
        end

        req_i      = 6'd0;
        fu_done_i  = 1'b0;
        fu_ready_i = 1'b0;
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fu_arb_6.md
# fu_arb_6

Round-robin arbiter and sequencer that shares one multi-cycle functional unit (e.g. divider) among six requesters. Winner selection uses two instances of the team's 6-input lowest-index priority encoder, one on rotated-masked requests and one on raw requests. The block owns the unit's start/ready/done handshake, returns per-requester grant and done pulses, and advances a fairness pointer after each completed operation.

## Interface
- TIMEOUT_CYCLES, 64: BUSY-state cycle limit before abort. Used only with the timeout macro. Range 2..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  6  request per requester. Held until its gnt_o pulse, or withdrawn.
- gnt_o  out  6  one-hot, one-cycle pulse when the unit accepts that requester's operation.
- done_o  out  6  one-hot, one-cycle pulse when the owner's operation completes.
- fu_start_o  out  1  start request to the unit.
- fu_sel_o  out  3  index of the current owner; operand mux select.
- fu_ready_i  in  1  unit accepts start this cycle.
- fu_done_i  in  1  unit result valid; single-cycle pulse.
- fu_abort_o  out  1  one-cycle pulse that kills the unit's operation.
- busy_o  out  1  high in ISSUE or BUSY.
- err_o  out  1  sticky timeout flag. Cleared only by reset.

## Operation
- State: IDLE, ISSUE, BUSY. Registers: state, owner idx (3b), ptr (3b, 0..5), timeout counter (8b).
- Arbitration (combinational), on candidate vector c:
  - m = c & thermometer mask of bits >= ptr.
  - win = enc(m) if m != 0, else enc(c).
  - any = |c.
- IDLE:
  - c = req_i.
  - If any: owner <= win, go to ISSUE.
- ISSUE:
  - fu_start_o = 1, fu_sel_o = owner.
  - If req_i[owner] == 0: withdrawal. Return to IDLE, no gnt, ptr unchanged. Withdrawal is checked before fu_ready_i.
  - Else if fu_ready_i: gnt_o[owner] = 1 (combinational pulse), go to BUSY, counter cleared.
- BUSY:
  - fu_sel_o = owner; owner's req is masked.
  - On fu_done_i:
    - done_o[owner] = 1.
    - ptr <= (owner == 5) ? 0 : owner + 1.
    - Arbitrate c = req_i & ~onehot(owner), using the updated ptr.
    - If any: owner <= win, go directly to ISSUE. Otherwise go to IDLE.
- Requesters drop req the cycle after gnt. A req re-asserted by the owner during BUSY competes only after its done.
- fu_done_i outside BUSY is ignored. fu_ready_i outside ISSUE is ignored.
- Reset (async, any state) clears all of the following immediately:
  - state = IDLE, owner = 0, ptr = 0, counter = 0, err_o = 0.
  - All outputs are 0. gnt_o, done_o, fu_start_o and fu_abort_o are decoded from state, so they read 0 while reset is asserted.

## Timing
- req_i rise in IDLE -> fu_start_o next cycle.
- ISSUE with fu_ready_i high -> gnt_o the same cycle, BUSY the next cycle.
- fu_done_i -> done_o the same cycle.
- Next fu_start_o:
  - 1 cycle after done if another request is pending (zero-bubble).
  - 2 cycles after done via IDLE otherwise.
- Minimum op occupancy: ISSUE 1 cycle + BUSY >= 1 cycle.

## Configuration
- FU_ARB_6_TIMEOUT_EN defined:
  - The counter increments each BUSY cycle without fu_done_i.
  - When it reaches TIMEOUT_CYCLES-1 without done:
    - fu_abort_o pulses and err_o is set.
    - No done_o; ptr advances as on done.
    - Go to IDLE.
  - A done arriving in the same cycle as expiry wins: normal completion, no abort.
- Undefined:
  - No counter is implemented; BUSY waits indefinitely.
  - fu_abort_o and err_o are tied 0. Ports remain present.

## Structure
- Package fu_arb_pkg:
  - N_REQ = 6, IDX_W = 3.
  - typedef enum logic [1:0] fu_arb_state_t {IDLE, ISSUE, BUSY}.
  - Function for the thermometer mask from ptr.
- Sub-module: the existing enc_6 priority encoder, instantiated twice (masked and unmasked). No other sub-modules.

## Test plan
- Reset, req_i=000000 -> all outputs 0, state IDLE; no fu_start_o over 10 cycles.
- ptr=0, req_i=100100, fu_ready=1, done 2 cycles after gnt:
  - First op: fu_sel=2, done_o=000100, ptr=3.
  - With req 100100 re-presented: the next grant is 100000 (fu_sel=5).
- req_i=111111 held (each drops after gnt, re-asserts after its done), fu_ready=1, done 3 cycles after gnt:
  - Grant order 0,1,2,3,4,5,0.
  - Zero-bubble ISSUE after each done.
- req_i=001000 with fu_ready=0 for 2 cycles, then req_i[3] drops -> return to IDLE, gnt_o never pulses, ptr unchanged.
- Assert rst_n=0 mid-BUSY (owner 4) -> all outputs 0 in the same cycle; after release, ptr=0 and req 010001 grants index 0.
- FU_ARB_6_TIMEOUT_EN, TIMEOUT_CYCLES=8, no fu_done_i:
  - fu_abort_o pulses on the 8th BUSY cycle, err_o=1 and stays set.
  - No done_o; state returns to IDLE.
